// File: rtl/ldm_stm_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsm_pkg
//  Purpose  : Shared definitions for the LDM/STM sequencer: sequencer state
//             encoding and default widths.
//  Revision : 1.0 - initial release
// ============================================================================
package lsm_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREG   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_XFER  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4
  } lsm_state_e;

endpackage
`default_nettype wire

// File: rtl/lsm_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : lsm_prio_enc
//  Purpose  : Lowest-set-bit priority encoder for the remaining register mask.
//  Ports    : mask  in  NREG   bit vector to encode
//             idx   out IDX_W  index of the lowest set bit (0 when mask == 0)
//             valid out 1      mask has at least one bit set
//  Revision : 1.0 - initial release
// ============================================================================
module lsm_prio_enc #(
  parameter int NREG  = 16,
  parameter int IDX_W = $clog2(NREG)
) (
  input  logic [NREG-1:0]  mask,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set bit is the last one to assign.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int n = NREG - 1; n >= 0; n--) begin
      if (mask[n]) begin
        idx   = IDX_W'(n);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ldm_stm_sequencer
//  Purpose  : Executes one multi-register load/store by walking the register
//             list lowest-first, one memory access per cycle, and writes
//             loaded words (and optionally the updated base) to the RF.
//  Ports    : clk/rst                      clock, sync active-high reset
//             start/is_load/base_addr/base_reg/reg_list/writeback  request
//             rf_rd_addr/rf_rd_data        RF read for store data
//             rf_we/rf_wr_addr/rf_wr_data  RF write for loads and base WB
//             mem_addr/mem_i/mem_wdata/mem_en/mem_load/mem_store/mem_rdata
//                                          memory-file port
//             busy/done                    status
//  Config   : LDM_STM_DESCENDING_EN adds input 'descending'; when set the
//             block occupies base-N .. base-1 and the base moves down by N.
//  Revision : 1.0 - initial release
// ============================================================================
module ldm_stm_sequencer
  import lsm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG   = DEF_NREG,
  localparam int IDX_W = $clog2(NREG),
  localparam int CNT_W = $clog2(NREG + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [IDX_W-1:0]  base_reg,
  input  logic [NREG-1:0]   reg_list,
  input  logic              writeback,
`ifdef LDM_STM_DESCENDING_EN
  input  logic              descending,
`endif
  output logic [IDX_W-1:0]  rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_i,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_load,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  lsm_state_e        r_state;
  logic [NREG-1:0]   r_mask;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_n;
  logic              r_load;
  logic              r_wb;      // pass through the WB state
  logic              r_wb_we;   // actually write the base in WB
  logic [ADDR_W-1:0] r_base;
  logic [IDX_W-1:0]  r_base_reg;
  logic [IDX_W-1:0]  r_pend;
  logic              r_pend_valid;
`ifdef LDM_STM_DESCENDING_EN
  logic              r_desc;
`endif

  logic [IDX_W-1:0]  w_idx;
  logic              w_valid;
  logic [NREG-1:0]   w_mask_next;
  logic [CNT_W-1:0]  w_list_n;
  logic              w_xfer;
  logic              w_pend_we;
  logic              w_wb_we;
  logic [ADDR_W-1:0] w_mem_base;
  logic [ADDR_W-1:0] w_wb_val;

  lsm_prio_enc #(.NREG(NREG), .IDX_W(IDX_W)) u_prio_enc (
    .mask  (r_mask),
    .idx   (w_idx),
    .valid (w_valid)
  );

  always_comb begin
    w_list_n = '0;
    for (int n = 0; n < NREG; n++) begin
      w_list_n = w_list_n + CNT_W'(reg_list[n]);
    end
  end

  assign w_mask_next = r_mask & ~({{(NREG-1){1'b0}}, 1'b1} << w_idx);
  assign w_xfer      = (r_state == ST_XFER) && w_valid;

  // Descending keeps the lowest register at the lowest address, so the
  // whole block simply shifts down by N; the new base equals that start.
`ifdef LDM_STM_DESCENDING_EN
  assign w_mem_base = r_desc ? (r_base - ADDR_W'(r_n)) : r_base;
  assign w_wb_val   = r_desc ? (r_base - ADDR_W'(r_n)) : (r_base + ADDR_W'(r_n));
`else
  assign w_mem_base = r_base;
  assign w_wb_val   = r_base + ADDR_W'(r_n);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_mask       <= '0;
      r_count      <= '0;
      r_n          <= '0;
      r_load       <= 1'b0;
      r_wb         <= 1'b0;
      r_wb_we      <= 1'b0;
      r_base       <= '0;
      r_base_reg   <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
`ifdef LDM_STM_DESCENDING_EN
      r_desc       <= 1'b0;
`endif
    end else begin
      // A load issued this cycle returns data next cycle.
      r_pend_valid <= w_xfer && r_load;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mask     <= reg_list;
            r_count    <= '0;
            r_n        <= w_list_n;
            r_load     <= is_load;
            r_wb       <= writeback;
            // A loaded base register takes the loaded value, not base+N.
            r_wb_we    <= writeback && !(is_load && reg_list[base_reg]);
            r_base     <= base_addr;
            r_base_reg <= base_reg;
`ifdef LDM_STM_DESCENDING_EN
            r_desc     <= descending;
`endif
            r_state    <= (reg_list == '0) ? ST_DONE : ST_XFER;
          end
        end
        ST_XFER: begin
          r_mask  <= w_mask_next;
          r_count <= r_count + CNT_W'(1);
          r_pend  <= w_idx;
          if (w_mask_next == '0) begin
            if (r_load)    r_state <= ST_DRAIN;
            else if (r_wb) r_state <= ST_WB;
            else           r_state <= ST_DONE;
          end
        end
        ST_DRAIN: r_state <= r_wb ? ST_WB : ST_DONE;
        ST_WB:    r_state <= ST_DONE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_pend_we = r_pend_valid && ((r_state == ST_XFER) || (r_state == ST_DRAIN));
  assign w_wb_we   = (r_state == ST_WB) && r_wb_we;

  assign mem_en     = w_xfer;
  assign mem_load   = w_xfer && r_load;
  assign mem_store  = w_xfer && !r_load;
  assign mem_i      = w_xfer ? ADDR_W'(r_count) : '0;
  assign mem_addr   = w_xfer ? w_mem_base : '0;
  assign rf_rd_addr = mem_store ? w_idx : '0;
  assign mem_wdata  = mem_store ? rf_rd_data : '0;

  assign rf_we      = w_pend_we || w_wb_we;
  assign rf_wr_addr = w_wb_we ? r_base_reg : (w_pend_we ? r_pend : '0);
  assign rf_wr_data = w_wb_we ? DATA_W'(w_wb_val) : (w_pend_we ? mem_rdata : '0);

  assign busy = (r_state == ST_XFER) || (r_state == ST_DRAIN) || (r_state == ST_WB);
  assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ldm_stm_sequencer
//  Purpose  : Self-checking bench for ldm_stm_sequencer with a 16-entry RF and
//             16-word memory environment plus a transaction-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [3:0]  base_reg = '0;
  logic [15:0] reg_list = '0;
  logic        writeback = 1'b0;
`ifdef LDM_STM_DESCENDING_EN
  logic        descending = 1'b0;
`endif
  logic [3:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic        rf_we;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_i;
  logic [31:0] mem_wdata;
  logic        mem_en;
  logic        mem_load;
  logic        mem_store;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  ldm_stm_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .base_addr  (base_addr),
    .base_reg   (base_reg),
    .reg_list   (reg_list),
    .writeback  (writeback),
`ifdef LDM_STM_DESCENDING_EN
    .descending (descending),
`endif
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data),
    .rf_we      (rf_we),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .mem_addr   (mem_addr),
    .mem_i      (mem_i),
    .mem_wdata  (mem_wdata),
    .mem_en     (mem_en),
    .mem_load   (mem_load),
    .mem_store  (mem_store),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done)
  );

  // Environment: register file and memory file driven by the DUT.
  logic [31:0] rf  [16];
  logic [31:0] mem [16];
  logic [31:0] m_rf  [16];
  logic [31:0] m_mem [16];
  logic        poke = 1'b0;
  logic [3:0]  w_maddr;

  assign w_maddr    = mem_addr[3:0] + mem_i[3:0];
  assign rf_rd_data = rf[rf_rd_addr];

  always @(posedge clk) begin
    if (poke) begin
      rf  <= m_rf;
      mem <= m_mem;
    end else begin
      if (rf_we)                 rf[rf_wr_addr] <= rf_wr_data;
      if (mem_en && mem_store)   mem[w_maddr]   <= mem_wdata;
      if (mem_en && mem_load)    mem_rdata      <= mem[w_maddr];
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic sync_env();
    @(negedge clk); poke = 1'b1;
    @(negedge clk); poke = 1'b0;
  endtask

  task automatic rand_data();
    for (int r = 0; r < 16; r++) begin
      m_rf[r]  = $urandom;
      m_mem[r] = $urandom;
    end
    sync_env();
  endtask

  task automatic compare_state(input string tag);
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("%s rf[%0d]", tag, r), 64'(rf[r]), 64'(m_rf[r]));
      chk($sformatf("%s mem[%0d]", tag, r), 64'(mem[r]), 64'(m_mem[r]));
    end
  endtask

  // One transaction: drive, watch every access, then check the architectural
  // result against the model.
  task automatic op(input string tag, input logic ld, input logic [7:0] base,
                    input logic [3:0] breg, input logic [15:0] list,
                    input logic wb, input bit busy_start);
    int n;
    int k;
    int cyc;
    int exp_cyc;
    logic [3:0] a;
    n = 0;
    for (int r = 0; r < 16; r++) begin
      if (list[r]) begin
        a = base[3:0] + 4'(n);
        if (ld) m_rf[r] = m_mem[a];
        else    m_mem[a] = m_rf[r];
        n++;
      end
    end
    if (wb && n != 0 && !(ld && list[breg]))
      m_rf[breg] = 32'(8'(base + 8'(n)));
    exp_cyc = (n == 0) ? 1 : n + int'(ld) + int'(wb) + 1;

    @(negedge clk);
    is_load = ld; base_addr = base; base_reg = breg; reg_list = list;
    writeback = wb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    k = 0;
    while (!done && cyc < 64) begin
      if (mem_en) begin
        chk($sformatf("%s mem_i", tag), 64'(mem_i), 64'(k));
        chk($sformatf("%s mem_addr", tag), 64'(mem_addr), 64'(base));
        chk($sformatf("%s mem_load", tag), 64'(mem_load), 64'(ld));
        k++;
      end
      if (busy_start && cyc == 1) begin
        start = 1'b1; reg_list = 16'hFFFF; is_load = ~ld;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk($sformatf("%s done", tag), 64'(done), 64'(1));
    chk($sformatf("%s latency", tag), 64'(cyc), 64'(exp_cyc));
    chk($sformatf("%s accesses", tag), 64'(k), 64'(n));
    compare_state(tag);
    @(negedge clk);
    chk($sformatf("%s idle", tag), 64'({busy, done, mem_en}), 64'(0));
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      m_rf[r]  = 32'h100 + 32'(r);
      m_mem[r] = 32'h200 + 32'(r);
    end
    sync_env();
    repeat (2) @(negedge clk);
    chk("reset outputs",
        64'({mem_en, mem_load, mem_store, rf_we, busy, done, mem_i, mem_addr}), 64'(0));
    chk("reset wdata", 64'({rf_wr_data, mem_wdata}), 64'(0));
    chk("reset rf_addr", 64'({rf_wr_addr, rf_rd_addr}), 64'(0));
    rst = 1'b0;

    // Directed cases
    m_mem[4] = 32'hA; m_mem[5] = 32'hB; sync_env();
    op("t1 ldm", 1'b1, 8'd4, 4'd0, 16'h0005, 1'b0, 1'b0);
    m_rf[1] = 32'h11; m_rf[3] = 32'h33; m_rf[15] = 32'hFF; sync_env();
    op("t2 stm", 1'b0, 8'd8, 4'd0, 16'h800A, 1'b0, 1'b0);
    op("t3 wb", 1'b0, 8'd2, 4'd13, 16'h0003, 1'b1, 1'b0);
    m_mem[0] = 32'd7; m_mem[1] = 32'd9; sync_env();
    op("t4 base in list", 1'b1, 8'd0, 4'd13, 16'h2001, 1'b1, 1'b0);
    op("t5 empty", 1'b1, 8'd5, 4'd0, 16'h0000, 1'b1, 1'b0);
    op("t5 busy start", 1'b0, 8'd1, 4'd2, 16'h00F0, 1'b0, 1'b1);
    op("wrap", 1'b0, 8'hFE, 4'd7, 16'hFFFF, 1'b1, 1'b0);

    // Reset in the middle of a 3-word load
    @(negedge clk);
    is_load = 1'b1; base_addr = 8'd3; base_reg = 4'd0; reg_list = 16'h0007;
    writeback = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("t6 abort enables", 64'({mem_en, mem_load, mem_store, rf_we}), 64'(0));
    chk("t6 abort status", 64'({busy, done}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("t6 stays idle", 64'({busy, done, mem_en}), 64'(0));
    rand_data();
    op("t6 after reset", 1'b1, 8'd3, 4'd1, 16'h0007, 1'b1, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      logic [15:0] l;
      if (t % 5 == 0) rand_data();
      l = 16'($urandom);
      if ($urandom_range(0, 5) == 0) l = '0;
      op($sformatf("rnd%0d", t), 1'($urandom), 8'($urandom), 4'($urandom),
         l, 1'($urandom), 1'($urandom_range(0, 3) == 0 && l != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
